// File: rtl/rvfi_liveness_pkg.sv
// rvfi_liveness_pkg: shared state encoding and order width for the liveness sequencer
package rvfi_liveness_pkg;
  localparam int ORDER_W = 64;
  typedef enum logic [1:0] {
    S_RESET  = 2'd0,
    S_WAIT   = 2'd1,
    S_WINDOW = 2'd2,
    S_DONE   = 2'd3
  } state_t;
endpackage

// File: rtl/rvfi_order_match.sv
// rvfi_order_match: flags any retire channel carrying a valid instruction of the target order
module rvfi_order_match
  import rvfi_liveness_pkg::*;
#(
  parameter int NRET = 1
) (
  input  logic [NRET-1:0]         i_valid,
  input  logic [ORDER_W*NRET-1:0] i_order,
  input  logic [ORDER_W-1:0]      i_target,
  output logic                    o_hit
);
  always_comb begin
    o_hit = 1'b0;
    for (int i = 0; i < NRET; i++)
      o_hit = o_hit | (i_valid[i] && i_order[ORDER_W*i +: ORDER_W] == i_target);
  end
endmodule

// File: rtl/rvfi_liveness_sequencer.sv
// rvfi_liveness_sequencer: drives liveness-checker reset/trig/check from the RVFI retire stream
module rvfi_liveness_sequencer
  import rvfi_liveness_pkg::*;
#(
  parameter int NRET         = 1,
  parameter int CHANNEL_IDX  = 0,
  parameter int RESET_CYCLES = 1,
  parameter int TRIG_CYCLE   = 10,
  parameter int CHECK_CYCLES = 20,
  parameter int CNT_W        = 16
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic [NRET-1:0]         i_rvfi_valid,
  input  logic [NRET-1:0]         i_rvfi_halt,
  input  logic [ORDER_W*NRET-1:0] i_rvfi_order,
  output logic                    o_chk_reset,
  output logic                    o_trig,
  output logic                    o_check,
  output logic [ORDER_W-1:0]      o_trig_order,
  output logic                    o_next_seen,
  output logic                    o_done,
  output logic [1:0]              o_state
);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TRIG_AT  = CNT_W'(TRIG_CYCLE);
  localparam logic [CNT_W-1:0] CHK_LAST = CNT_W'(CHECK_CYCLES - 1);

  if (CHANNEL_IDX >= NRET || CHANNEL_IDX < 0) begin : g_bad_channel
    $error("CHANNEL_IDX must be in 0..NRET-1");
  end
  if (RESET_CYCLES < 1) begin : g_bad_reset
    $error("RESET_CYCLES must be >= 1");
  end
  if (CHECK_CYCLES < 1) begin : g_bad_check
    $error("CHECK_CYCLES must be >= 1");
  end

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [ORDER_W-1:0]   r_trig_order;
  logic                 r_next_seen;
  logic [ORDER_W-1:0]   w_ch_order;
  logic [ORDER_W-1:0]   w_target;
  logic                 w_hit;
  logic                 w_trig;
  logic                 w_unused;

  assign w_ch_order = i_rvfi_order[ORDER_W*CHANNEL_IDX +: ORDER_W];
  assign w_trig     = r_state == S_WAIT && r_cnt == TRIG_AT &&
                      i_rvfi_valid[CHANNEL_IDX] && !i_rvfi_halt[CHANNEL_IDX];
  // In the trig cycle the successor is searched relative to the order being sampled now
  assign w_target   = (r_state == S_WAIT ? w_ch_order : r_trig_order) + 64'd1;
  assign w_unused   = ^i_rvfi_halt;

  rvfi_order_match #(.NRET(NRET)) u_match (
    .i_valid  (i_rvfi_valid),
    .i_order  (i_rvfi_order),
    .i_target (w_target),
    .o_hit    (w_hit)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_RESET;
      r_cnt        <= '0;
      r_trig_order <= '0;
      r_next_seen  <= 1'b0;
    end else begin
      case (r_state)
        S_RESET: begin
          r_state <= r_cnt == RST_LAST ? S_WAIT : S_RESET;
          r_cnt   <= r_cnt == RST_LAST ? '0 : r_cnt + 1'b1;
        end
        S_WAIT: begin
          if (w_trig) begin
            r_state      <= S_WINDOW;
            r_cnt        <= '0;
            r_trig_order <= w_ch_order;
            r_next_seen  <= r_next_seen | w_hit;
          end else if (r_cnt != TRIG_AT) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WINDOW: begin
          r_next_seen <= r_next_seen | w_hit;
          r_state     <= r_cnt == CHK_LAST ? S_DONE : S_WINDOW;
          r_cnt       <= r_cnt == CHK_LAST ? r_cnt : r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_chk_reset  = r_state == S_RESET;
  assign o_trig       = w_trig;
  assign o_check      = r_state == S_WINDOW && r_cnt == CHK_LAST;
  assign o_trig_order = r_trig_order;
  assign o_next_seen  = r_next_seen;
  assign o_done       = r_state == S_DONE;
  assign o_state      = r_state;
endmodule

// File: tb/tb_rvfi_liveness_sequencer.sv
// tb_rvfi_liveness_sequencer: directed checks of reset hold, trig timing, check window and next_seen
module tb_rvfi_liveness_sequencer;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   valid = '0;
  logic [1:0]   halt = '0;
  logic [127:0] order = '0;
  logic         chk_reset, trig, check, next_seen, done;
  logic [63:0]  trig_order;
  logic [1:0]   state;
  int checks = 0, failures = 0, stepn = 0;

  rvfi_liveness_sequencer #(
    .NRET(2), .CHANNEL_IDX(0), .RESET_CYCLES(3), .TRIG_CYCLE(5), .CHECK_CYCLES(4), .CNT_W(16)
  ) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_rvfi_valid (valid),
    .i_rvfi_halt  (halt),
    .i_rvfi_order (order),
    .o_chk_reset  (chk_reset),
    .o_trig       (trig),
    .o_check      (check),
    .o_trig_order (trig_order),
    .o_next_seen  (next_seen),
    .o_done       (done),
    .o_state      (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s step=%0d got=%h exp=%h", tag, stepn, got, exp);
    end
  endtask

  task automatic step(input logic v0, input logic h0, input logic [63:0] o0,
                      input logic v1, input logic [63:0] o1,
                      input logic et, input logic ec, input logic [1:0] es);
    @(negedge clk);
    stepn++;
    valid = {v1, v0};
    halt  = {1'b0, h0};
    order = {o1, o0};
    #1;
    chk("trig", 64'(trig), 64'(et));
    chk("check", 64'(check), 64'(ec));
    chk("state", 64'(state), 64'(es));
    chk("chk_reset", 64'(chk_reset), 64'(es == 2'd0));
    chk("done", 64'(done), 64'(es == 2'd3));
  endtask

  task automatic idle(input logic [1:0] es, input int n);
    repeat (n) step(0, 0, 64'd0, 0, 64'd0, 0, 0, es);
  endtask

  task automatic rst_pulse();
    valid = '0;
    halt  = '0;
    order = '0;
    rst   = 1'b1;
    #1;
    chk("rst_chk_reset", 64'(chk_reset), 64'd1);
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_check", 64'(check), 64'd0);
    chk("rst_trig_order", trig_order, 64'd0);
    chk("rst_next_seen", 64'(next_seen), 64'd0);
    @(negedge clk);
    #1;
    chk("rst_hold_check", 64'(check), 64'd0);
    chk("rst_hold_done", 64'(done), 64'd0);
    rst = 1'b0;
    #1;
    chk("rel_state", 64'(state), 64'd0);
  endtask

  initial begin
    // basic sequence: reset hold 3, trig on order 5, check 4 later
    rst_pulse();
    idle(0, 2);
    idle(1, 1);
    for (int o = 1; o <= 4; o++) step(1, 0, 64'(o), 0, 64'd0, 0, 0, 1);
    step(1, 0, 64'd5, 0, 64'd0, 1, 0, 1);
    step(1, 0, 64'd6, 0, 64'd0, 0, 0, 2);
    step(1, 0, 64'd7, 0, 64'd0, 0, 0, 2);
    step(1, 0, 64'd8, 0, 64'd0, 0, 0, 2);
    step(1, 0, 64'd9, 0, 64'd0, 0, 1, 2);
    idle(3, 1);
    chk("t1_trig_order", trig_order, 64'd5);
    chk("t1_next_seen", 64'(next_seen), 64'd1);
    step(1, 0, 64'd10, 0, 64'd0, 0, 0, 3);
    // halted retirement at the eligible cycle, retry succeeds two cycles later
    rst_pulse();
    idle(0, 2);
    idle(1, 1);
    for (int o = 1; o <= 4; o++) step(1, 0, 64'(o), 0, 64'd0, 0, 0, 1);
    step(1, 1, 64'd5, 0, 64'd0, 0, 0, 1);
    idle(1, 1);
    step(1, 0, 64'd9, 0, 64'd0, 1, 0, 1);
    idle(2, 3);
    step(0, 0, 64'd0, 0, 64'd0, 0, 1, 2);
    idle(3, 1);
    chk("t2_trig_order", trig_order, 64'd9);
    chk("t2_next_seen", 64'(next_seen), 64'd0);
    // other channel alone cannot trigger; same-cycle successor on ch1 counts
    rst_pulse();
    idle(0, 2);
    idle(1, 5);
    step(0, 0, 64'd0, 1, 64'd3, 0, 0, 1);
    step(1, 0, 64'd7, 1, 64'd8, 1, 0, 1);
    idle(2, 1);
    chk("t3_next_seen_early", 64'(next_seen), 64'd1);
    idle(2, 2);
    step(0, 0, 64'd0, 0, 64'd0, 0, 1, 2);
    idle(3, 1);
    chk("t3_trig_order", trig_order, 64'd7);
    chk("t3_next_seen", 64'(next_seen), 64'd1);
    // stalled core: check fires without next_seen
    rst_pulse();
    idle(0, 2);
    idle(1, 5);
    step(1, 0, 64'd4, 0, 64'd0, 1, 0, 1);
    idle(2, 3);
    step(0, 0, 64'd0, 0, 64'd0, 0, 1, 2);
    idle(3, 1);
    chk("t4_trig_order", trig_order, 64'd4);
    chk("t4_next_seen", 64'(next_seen), 64'd0);
    // async reset mid-window aborts, then the sequence reruns cleanly
    rst_pulse();
    idle(0, 2);
    idle(1, 5);
    step(1, 0, 64'd20, 0, 64'd0, 1, 0, 1);
    idle(2, 3);
    #1;
    rst_pulse();
    idle(0, 2);
    idle(1, 5);
    step(1, 0, 64'd30, 0, 64'd0, 1, 0, 1);
    idle(2, 3);
    step(0, 0, 64'd0, 0, 64'd0, 0, 1, 2);
    idle(3, 1);
    chk("t5_trig_order", trig_order, 64'd30);
    // successor of the maximum order wraps to zero
    rst_pulse();
    idle(0, 2);
    idle(1, 5);
    step(1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'd0, 1, 0, 1);
    step(1, 0, 64'd0, 0, 64'd0, 0, 0, 2);
    chk("t6_next_seen_pre", 64'(next_seen), 64'd0);
    idle(2, 1);
    chk("t6_next_seen", 64'(next_seen), 64'd1);
    idle(2, 1);
    step(0, 0, 64'd0, 0, 64'd0, 0, 1, 2);
    idle(3, 1);
    chk("t6_trig_order", trig_order, 64'hFFFF_FFFF_FFFF_FFFF);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rvfi_liveness_sequencer.md
Name: rvfi_liveness_sequencer

Overview:
Stimulus/timing sequencer directly upstream of the RVFI liveness checker; drives that checker's reset, trig and check inputs from the core's RVFI retire stream.
- Holds the checker in reset for a fixed number of cycles.
- Fires trig on the first eligible retirement on the checked channel after a programmable cycle.
- Fires check a fixed window later.
- Also mirrors the "next instruction retired" search so simulation benches can see the expected verdict.

Parameters:
NRET, 1, number of RVFI retire channels
CHANNEL_IDX, 0, channel whose retirement is the trigger candidate (0..NRET-1)
RESET_CYCLES, 1, cycles chk_reset is held high after reset release (>=1)
TRIG_CYCLE, 10, earliest cycle count, measured from leaving S_RESET, at which trig may fire
CHECK_CYCLES, 20, cycles from trig to check (>=1)
CNT_W, 16, cycle counter width; must hold max(RESET_CYCLES, TRIG_CYCLE, CHECK_CYCLES)

Ports:
clock  in  1  sole clock, rising edge
reset  in  1  asynchronous, active-high; returns block to S_RESET
rvfi_valid  in  NRET  per-channel retire valid
rvfi_halt  in  NRET  per-channel halt flag
rvfi_order  in  64*NRET  per-channel instruction order, channel i at [64*i +: 64]
chk_reset  out  1  reset to checker
trig  out  1  one-cycle trigger, combinational with RVFI inputs
check  out  1  one-cycle check strobe
trig_order  out  64  order latched at trig
next_seen  out  1  sticky: order trig_order+1 retired on any channel since trig
done  out  1  sequence complete
state  out  2  current FSM state, for debug

Behaviour:
- States, kept in a 2-bit register:
  - S_RESET=0: chk_reset=1; cnt counts 0..RESET_CYCLES-1, then go to S_WAIT with cnt=0.
  - S_WAIT=1: cnt increments and saturates at TRIG_CYCLE.
    - trig = (cnt==TRIG_CYCLE) && rvfi_valid[CHANNEL_IDX] && !rvfi_halt[CHANNEL_IDX]. This is combinational, so trig is coincident with the retirement it samples.
    - On trig: latch trig_order = rvfi_order of CHANNEL_IDX, set cnt=0, go to S_WINDOW.
  - S_WINDOW=2: cnt increments; check=1 in the cycle where cnt==CHECK_CYCLES-1, then go to S_DONE.
  - S_DONE=3: done=1; all strobes 0; remain until reset.
- Async reset clears everything (state S_RESET, cnt=0, trig_order=0, next_seen=0). Output values while in reset: chk_reset=1, trig=0, check=0, done=0.
- Reset asserted in any state, including mid-window or in the check cycle, aborts immediately. No check is issued.
- Halted retirement on CHANNEL_IDX at the eligible cycle: no trig; S_WAIT holds and tries again every later cycle.
- Retirement on another channel does not trigger.
- next_seen, evaluated in S_WINDOW and in the trig cycle:
  - Set when any channel has valid && order == trig_order+1; in the trig cycle, compare against the sampled order+1.
  - The +1 is 64-bit modulo (order 2^64-1 expects 0).
  - A same-cycle retirement of order+1 on another channel in the trig cycle counts.
  - Cleared only by reset; frozen in S_DONE.
- check and trig are never high together, even with CHECK_CYCLES=1: check then falls in the cycle after trig.
- Counters saturate, never wrap.
- Elaboration error if CHANNEL_IDX>=NRET, RESET_CYCLES<1 or CHECK_CYCLES<1.

Decomposition:
- Package rvfi_liveness_pkg: state typedef (S_RESET/S_WAIT/S_WINDOW/S_DONE), ORDER_W=64.
- One sub-module, rvfi_order_match: combinational search over NRET channels for valid && order==target; output a 1-bit hit.
- Reuse rvfi_order_match for the next_seen update.

Test Plan:
1. RESET_CYCLES=3, TRIG_CYCLE=5, CHECK_CYCLES=4; retire orders 1,2,3... every cycle on ch0 → chk_reset high for 3 cycles; trig 5 cycles after S_WAIT entry with trig_order=5; check exactly 4 cycles later; next_seen=1; done=1 after.
2. Halt asserted with the retirement at the eligible cycle, then a valid non-halt retirement 2 cycles later (order 9) → no trig at the halted cycle; trig fires 2 cycles later with trig_order=9.
3. NRET=2, CHANNEL_IDX=0; trig on order 7 while ch1 retires order 8 in the same cycle; no further retirement → next_seen=1 from the trig cycle; check fires on schedule.
4. After trig on order 4, the core stalls (no valid) for the whole window → check fires with next_seen=0; done=1.
5. Async reset pulsed mid-window (cnt=2 of 4) → chk_reset=1 immediately; check never fires; the sequence restarts from S_RESET and re-triggers normally.
6. trig_order=64'hFFFF_FFFF_FFFF_FFFF, next retirement order 0 → next_seen=1 (wrap-around).
